// File: rtl/down_counter_timer.sv
// Loadable down-counter / timer with one-shot and auto-reload modes.
// Counts a programmed value down to zero on enabled cycles and pulses tc
// on the cycle after the terminal step. All outputs are registered.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing loaded (or zero loaded); enable ignored, count held
// RUN   | counting down on enabled cycles; busy high
// DONE  | one-shot expired; count held at 0, done high until load/reset

module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             enable_i,
   input  logic             auto_reload_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             term_step;

   // The step that takes count from 1 to its end value; a load in the
   // same cycle wins, so no tc is produced then.
   assign term_step = !load_i && (state_q == S_RUN) && enable_i
                      && (count_q == WIDTH'(1));

   // State and datapath registers; reset beats load beats enable.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next state plus next count/reload value.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      if (load_i) begin
         reload_d = load_val_i;
         count_d  = load_val_i;
         state_d  = (load_val_i != '0) ? S_RUN : S_IDLE;
      end else if ((state_q == S_RUN) && enable_i) begin
         if (count_q == WIDTH'(1)) begin
            // Periodic mode jumps straight back to the reload value so the
            // period is exactly N enabled cycles with no visible zero.
            if (auto_reload_i) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = S_DONE;
            end
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   // Next values of the registered status outputs.
   always_comb begin
      tc_d   = term_step;
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign count_o = count_q;
   assign tc_o    = tc_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the timer.

module tb_down_counter_timer;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         load;
   logic [W-1:0] load_val;
   logic         enable;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         tc, busy, done;

   int vectors    = 0;
   int miscompares = 0;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .load_i        (load),
      .load_val_i    (load_val),
      .enable_i      (enable),
      .auto_reload_i (auto_reload),
      .count_o       (count),
      .tc_o          (tc),
      .busy_o        (busy),
      .done_o        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: value left to count, programmed period, and whether
   // the timer is running or has expired.
   int  m_left   = 0;
   int  m_period = 0;
   bit  m_run    = 0;
   bit  m_exp    = 0;
   bit  m_tc     = 0;
   bit  m_valid  = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_left = 0; m_period = 0; m_run = 0; m_exp = 0; m_tc = 0;
         m_valid = 1;
      end else if (load) begin
         m_period = int'(load_val);
         m_left   = int'(load_val);
         m_run    = (load_val != 0);
         m_exp    = 0;
         m_tc     = 0;
      end else if (m_run && enable) begin
         m_left = m_left - 1;
         m_tc   = (m_left == 0);
         if (m_left == 0) begin
            if (auto_reload) m_left = m_period;
            else begin m_run = 0; m_exp = 1; end
         end
      end else begin
         m_tc = 0;
      end
      #1;
      if (m_valid) begin
         vectors++;
         if (int'(count) != m_left || tc !== m_tc || busy !== m_run
             || done !== m_exp) begin
            miscompares++;
            $display("FAIL model t=%0t count=%0d tc=%0b busy=%0b done=%0b expected count=%0d tc=%0b busy=%0b done=%0b",
                     $time, count, tc, busy, done, m_left, m_tc, m_run, m_exp);
         end
      end
   end

   // One clock: inputs applied at negedge, outputs settled 2 after posedge.
   task automatic cyc(input bit r, input bit l, input logic [W-1:0] lv,
                      input bit en, input bit ar);
      @(negedge clk);
      reset = r; load = l; load_val = lv; enable = en; auto_reload = ar;
      @(posedge clk);
      #2;
   endtask

   task automatic pin(input string name, input int c, input bit t,
                      input bit b, input bit d);
      vectors++;
      if (int'(count) != c || tc !== t || busy !== b || done !== d) begin
         miscompares++;
         $display("FAIL %s count=%0d tc=%0b busy=%0b done=%0b expected count=%0d tc=%0b busy=%0b done=%0b",
                  name, count, tc, busy, done, c, t, b, d);
      end
   endtask

   int exp_seq[$];
   bit exp_tc[$];

   initial begin
      reset = 1'b0; load = 1'b1; load_val = 4'd9; enable = 1'b0; auto_reload = 1'b0;

      // Reset held two clocks with a competing load
      cyc(0, 1, 4'd9, 0, 0);
      cyc(0, 1, 4'd9, 0, 0);
      pin("reset", 0, 0, 0, 0);
      cyc(1, 0, 4'd0, 1, 0);
      pin("idle_enable_ignored", 0, 0, 0, 0);

      // One-shot of 5
      cyc(1, 1, 4'd5, 1, 0);
      pin("oneshot_load", 5, 0, 1, 0);
      exp_seq = '{4, 3, 2, 1};
      foreach (exp_seq[i]) begin
         cyc(1, 0, 4'd0, 1, 0);
         pin("oneshot_down", exp_seq[i], 0, 1, 0);
      end
      cyc(1, 0, 4'd0, 1, 0);
      pin("oneshot_tc", 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 4'd0, 1, 0);
         pin("oneshot_hold", 0, 0, 0, 1);
      end

      // Auto-reload of 3
      cyc(1, 1, 4'd3, 1, 1);
      pin("auto_load", 3, 0, 1, 0);
      exp_seq = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      exp_tc  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
      foreach (exp_seq[i]) begin
         cyc(1, 0, 4'd0, 1, 1);
         pin("auto_period", exp_seq[i], exp_tc[i], 1, 0);
      end

      // Enable gating
      cyc(1, 1, 4'd4, 0, 0);
      pin("gate_load", 4, 0, 1, 0);
      exp_seq = '{3, 3, 3, 2, 1, 1, 0};
      exp_tc  = '{0, 0, 0, 0, 0, 0, 1};
      begin
         bit en_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
         foreach (exp_seq[i]) begin
            cyc(1, 0, 4'd0, en_pat[i], 0);
            pin("gate_step", exp_seq[i], exp_tc[i], exp_seq[i] != 0, exp_seq[i] == 0);
         end
      end

      // Restart mid-count, then zero load
      cyc(1, 1, 4'd6, 1, 0);
      cyc(1, 0, 4'd0, 1, 0);
      cyc(1, 0, 4'd0, 1, 0);
      pin("restart_pre", 4, 0, 1, 0);
      cyc(1, 1, 4'd2, 1, 0);
      pin("restart_no_dec", 2, 0, 1, 0);
      cyc(1, 1, 4'd0, 1, 0);
      pin("zero_load", 0, 0, 0, 0);
      cyc(1, 0, 4'd0, 1, 1);
      pin("zero_load_hold", 0, 0, 0, 0);

      // Reset mid-count, then full-scale period
      cyc(1, 1, 4'd15, 1, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 4'd0, 1, 0);
      pin("max_run7", 8, 0, 1, 0);
      cyc(0, 0, 4'd0, 1, 0);
      pin("reset_mid", 0, 0, 0, 0);
      cyc(1, 1, 4'd15, 1, 0);
      pin("max_load", 15, 0, 1, 0);
      for (int i = 1; i <= 15; i++) begin
         cyc(1, 0, 4'd0, 1, 0);
         if (i < 15) pin("max_count", 15 - i, 0, 1, 0);
         else        pin("max_tc", 0, 1, 0, 1);
      end

      // Auto-reload of 1: tc every enabled cycle
      cyc(1, 1, 4'd1, 1, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 4'd0, 1, 1);
         pin("reload1", 1, 1, 1, 0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bit          r  = ($urandom_range(0, 59) != 0);
         bit          l  = ($urandom_range(0, 9) == 0);
         logic [W-1:0] lv = W'($urandom_range(0, 15));
         bit          en = ($urandom_range(0, 3) != 0);
         bit          ar = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) lv = (lv[0]) ? 4'd0 : 4'd1;
         cyc(r, l, lv, en, ar);
      end

      cyc(1, 0, 4'd0, 0, 0);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
